// File: rtl/axil_sir_bridge_if.sv
// Bus bundle for the AXI4-Lite to Sir bridge: AXI-Lite slave side plus Sir master side.
// The slave modport is the bridge view; master is the upstream AXI master / Sir slave fabric.
interface axil_sir_bridge_if #(
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned DATAWIDTH = 32
);
    logic [ADDRWIDTH+1:0] s_awaddr;
    logic                 s_awvalid;
    logic                 s_awready;
    logic [DATAWIDTH-1:0] s_wdata;
    logic                 s_wvalid;
    logic                 s_wready;
    logic [1:0]           s_bresp;
    logic                 s_bvalid;
    logic                 s_bready;
    logic [ADDRWIDTH+1:0] s_araddr;
    logic                 s_arvalid;
    logic                 s_arready;
    logic [DATAWIDTH-1:0] s_rdata;
    logic [1:0]           s_rresp;
    logic                 s_rvalid;
    logic                 s_rready;
    logic                 SirSel;
    logic                 SirRead;
    logic                 SirWrite;
    logic [ADDRWIDTH-1:0] SirAddr;
    logic [DATAWIDTH-1:0] SirWdat;
    logic                 SirDack;
    logic [DATAWIDTH-1:0] SirRdat;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, SirDack, SirRdat,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output SirSel, SirRead, SirWrite, SirAddr, SirWdat
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, SirDack, SirRdat,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  SirSel, SirRead, SirWrite, SirAddr, SirWdat
    );
endinterface

// File: rtl/axil_sir_bridge.sv
// AXI4-Lite slave to Sir register-bus master: one AXI read or write becomes one Sir access,
// with round-robin read/write arbitration and a no-ack timeout that returns SLVERR.
module axil_sir_bridge #(
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic              clk,
    input logic              rst,
    axil_sir_bridge_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSel, StWaitAck, StResp} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic                 r_last_wr;
    logic                 r_is_wr;
    logic                 r_sir_sel;
    logic                 r_sir_read;
    logic                 r_sir_write;
    logic [ADDRWIDTH-1:0] r_sir_addr;
    logic [DATAWIDTH-1:0] r_sir_wdat;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [DATAWIDTH-1:0] r_rdata;

    logic w_wr_elig;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_timeout;
    logic w_resp_done;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};

    // Round-robin: the read side wins a tie only when the previous grant was a write.
    assign w_wr_elig  = bus.s_awvalid & bus.s_wvalid;
    assign w_grant_wr = ~rst & (r_state == StIdle) & w_wr_elig & (~bus.s_arvalid | ~r_last_wr);
    assign w_grant_rd = ~rst & (r_state == StIdle) & bus.s_arvalid & (~w_wr_elig | r_last_wr);
    assign w_timeout   = (r_cnt == CntW'(TIMEOUT - 1));
    assign w_resp_done = r_is_wr ? bus.s_bready : bus.s_rready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (w_grant_wr || w_grant_rd) w_state_next = StSel;
            StSel:     w_state_next = StWaitAck;
            StWaitAck: if (bus.SirDack || w_timeout) w_state_next = StResp;
            StResp:    if (w_resp_done) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_last_wr   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_sir_sel   <= 1'b0;
            r_sir_read  <= 1'b0;
            r_sir_write <= 1'b0;
            r_sir_addr  <= '0;
            r_sir_wdat  <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_rvalid    <= 1'b0;
            r_rresp     <= 2'b00;
            r_rdata     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sir_sel <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant_wr) begin
                        r_is_wr     <= 1'b1;
                        r_last_wr   <= 1'b1;
                        r_sir_sel   <= 1'b1;
                        r_sir_write <= 1'b1;
                        r_sir_addr  <= bus.s_awaddr[ADDRWIDTH+1:2];
                        r_sir_wdat  <= bus.s_wdata;
                    end else if (w_grant_rd) begin
                        r_is_wr     <= 1'b0;
                        r_last_wr   <= 1'b0;
                        r_sir_sel   <= 1'b1;
                        r_sir_read  <= 1'b1;
                        r_sir_addr  <= bus.s_araddr[ADDRWIDTH+1:2];
                        r_sir_wdat  <= '0;
                    end
                end
                StWaitAck: begin
                    r_cnt <= r_cnt + CntW'(1);
                    // An ack arriving on the timeout cycle still counts as success.
                    if (bus.SirDack || w_timeout) begin
                        r_sir_read  <= 1'b0;
                        r_sir_write <= 1'b0;
                        r_sir_addr  <= '0;
                        r_sir_wdat  <= '0;
                        if (r_is_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= bus.SirDack ? 2'b00 : 2'b10;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= bus.SirDack ? 2'b00 : 2'b10;
                            r_rdata  <= bus.SirDack ? bus.SirRdat : '0;
                        end
                    end
                end
                StResp: begin
                    if (w_resp_done) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= 2'b00;
                        r_rvalid <= 1'b0;
                        r_rresp  <= 2'b00;
                        r_rdata  <= '0;
                        r_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_awready = w_grant_wr;
    assign bus.s_wready  = w_grant_wr;
    assign bus.s_arready = w_grant_rd;
    assign bus.s_bvalid  = r_bvalid;
    assign bus.s_bresp   = r_bresp;
    assign bus.s_rvalid  = r_rvalid;
    assign bus.s_rresp   = r_rresp;
    assign bus.s_rdata   = r_rdata;
    assign bus.SirSel    = r_sir_sel;
    assign bus.SirRead   = r_sir_read;
    assign bus.SirWrite  = r_sir_write;
    assign bus.SirAddr   = r_sir_addr;
    assign bus.SirWdat   = r_sir_wdat;
endmodule

// File: tb/tb_axil_sir_bridge.sv
// Bench for axil_sir_bridge: transaction-timeline model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_axil_sir_bridge;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    axil_sir_bridge_if #(.ADDRWIDTH(8), .DATAWIDTH(32)) bus ();

    axil_sir_bridge #(.ADDRWIDTH(8), .DATAWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sir slave fabric: acks one cycle after SirSel; read data = 0xC2 + word address.
    logic        slave_auto = 1'b1;
    logic        inject_dack = 1'b0;
    logic [31:0] inject_data = 32'h0;
    logic        sel_seen;
    logic        inj_seen;

    initial begin
        bus.SirDack = 1'b0;
        bus.SirRdat = 32'h0;
        forever begin
            @(negedge clk);
            sel_seen = bus.SirSel;
            inj_seen = inject_dack;
            @(posedge clk);
            #1;
            bus.SirDack = (slave_auto && sel_seen) || inj_seen;
            if (inj_seen) bus.SirRdat = inject_data;
            else if (bus.SirDack && bus.SirRead) bus.SirRdat = 32'hC2 + 32'(bus.SirAddr);
            else bus.SirRdat = 32'h0;
        end
    end

    // Model: one transaction tracked by its age in cycles since the handshake (age 1 = Sel
    // strobe, age >= 2 = waiting for ack), then a response phase until the AXI ready.
    logic        m_live = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_fin = 1'b0;
    logic        m_is_wr = 1'b0;
    logic        m_last_wr = 1'b0;
    int          m_age = 0;
    logic [7:0]  m_addr = 8'h0;
    logic [31:0] m_wdat = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_resp = 2'b0;

    logic exp_gw, exp_gr, exp_acc, exp_bv, exp_rv;
    assign exp_gw = !rst && m_live && !m_busy && bus.s_awvalid && bus.s_wvalid &&
                    (!bus.s_arvalid || !m_last_wr);
    assign exp_gr = !rst && m_live && !m_busy && bus.s_arvalid &&
                    (!(bus.s_awvalid && bus.s_wvalid) || m_last_wr);
    assign exp_acc = m_busy && !m_fin;
    assign exp_bv  = m_busy && m_fin && m_is_wr;
    assign exp_rv  = m_busy && m_fin && !m_is_wr;

    always @(posedge clk) begin
        if (rst) begin
            m_live    <= 1'b1;
            m_busy    <= 1'b0;
            m_last_wr <= 1'b0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (exp_gw) begin
                    m_busy <= 1'b1; m_is_wr <= 1'b1; m_last_wr <= 1'b1; m_age <= 1;
                    m_fin <= 1'b0; m_addr <= bus.s_awaddr[9:2]; m_wdat <= bus.s_wdata;
                end else if (exp_gr) begin
                    m_busy <= 1'b1; m_is_wr <= 1'b0; m_last_wr <= 1'b0; m_age <= 1;
                    m_fin <= 1'b0; m_addr <= bus.s_araddr[9:2]; m_wdat <= 32'h0;
                end
            end else if (!m_fin) begin
                m_age <= m_age + 1;
                if (m_age >= 2 && bus.SirDack) begin
                    m_fin <= 1'b1; m_resp <= 2'b00; m_rdata <= m_is_wr ? 32'h0 : bus.SirRdat;
                end else if (m_age - 1 == TIMEOUT) begin
                    m_fin <= 1'b1; m_resp <= 2'b10; m_rdata <= 32'h0;
                end
            end else if (m_is_wr ? bus.s_bready : bus.s_rready) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("awready", 32'(bus.s_awready), 32'(exp_gw));
            chk("wready", 32'(bus.s_wready), 32'(exp_gw));
            chk("arready", 32'(bus.s_arready), 32'(exp_gr));
            chk("SirSel", 32'(bus.SirSel), 32'(exp_acc && m_age == 1));
            chk("SirRead", 32'(bus.SirRead), 32'(exp_acc && !m_is_wr));
            chk("SirWrite", 32'(bus.SirWrite), 32'(exp_acc && m_is_wr));
            chk("SirAddr", 32'(bus.SirAddr), exp_acc ? 32'(m_addr) : 32'h0);
            chk("SirWdat", bus.SirWdat, exp_acc ? m_wdat : 32'h0);
            chk("bvalid", 32'(bus.s_bvalid), 32'(exp_bv));
            chk("bresp", 32'(bus.s_bresp), exp_bv ? 32'(m_resp) : 32'h0);
            chk("rvalid", 32'(bus.s_rvalid), 32'(exp_rv));
            chk("rresp", 32'(bus.s_rresp), exp_rv ? 32'(m_resp) : 32'h0);
            chk("rdata", bus.s_rdata, exp_rv ? m_rdata : 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [3:0] ord;
    int         ng;
    logic       got;

    initial begin
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wvalid = 1'b0;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_bvalid", 32'(bus.s_bvalid), 32'h0);
        chk("rst_rvalid", 32'(bus.s_rvalid), 32'h0);
        chk("rst_sirsel", 32'(bus.SirSel), 32'h0);
        rst = 1'b0;
        tick();

        // Write 0x014 <- 0xA5A50001
        bus.s_awaddr = 10'h014; bus.s_wdata = 32'hA5A5_0001;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(negedge clk);
        chk("wr_awready", 32'(bus.s_awready), 32'h1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        @(negedge clk);
        chk("wr_sel", 32'(bus.SirSel), 32'h1);
        chk("wr_addr", 32'(bus.SirAddr), 32'h05);
        chk("wr_write", 32'(bus.SirWrite), 32'h1);
        chk("wr_wdat", bus.SirWdat, 32'hA5A5_0001);
        tick(); tick();
        @(negedge clk);
        chk("wr_bvalid_t3", 32'(bus.s_bvalid), 32'h1);
        chk("wr_bresp", 32'(bus.s_bresp), 32'h0);
        tick(); tick();

        // Read 0x004 -> 0xC3
        bus.s_araddr = 10'h004; bus.s_arvalid = 1'b1;
        @(negedge clk);
        chk("rd_arready", 32'(bus.s_arready), 32'h1);
        tick();
        bus.s_arvalid = 1'b0;
        @(negedge clk);
        chk("rd_read", 32'(bus.SirRead), 32'h1);
        chk("rd_write", 32'(bus.SirWrite), 32'h0);
        tick(); tick();
        @(negedge clk);
        chk("rd_rvalid_t3", 32'(bus.s_rvalid), 32'h1);
        chk("rd_rdata", bus.s_rdata, 32'h0000_00C3);
        chk("rd_rresp", 32'(bus.s_rresp), 32'h0);
        tick(); tick();

        // Timeout: no ack for 16 wait cycles
        slave_auto = 1'b0;
        bus.s_araddr = 10'h3FC; bus.s_arvalid = 1'b1;
        @(negedge clk);
        chk("to_arready", 32'(bus.s_arready), 32'h1);
        tick();
        bus.s_arvalid = 1'b0;
        repeat (16) tick();
        @(negedge clk);
        chk("to_rvalid_early", 32'(bus.s_rvalid), 32'h0);
        tick();
        @(negedge clk);
        chk("to_rvalid", 32'(bus.s_rvalid), 32'h1);
        chk("to_rresp", 32'(bus.s_rresp), 32'h2);
        chk("to_rdata", bus.s_rdata, 32'h0);
        tick(); tick();

        // Ack on the 16th wait cycle wins over the timeout
        inject_data = 32'h1234_5678;
        bus.s_araddr = 10'h3F0; bus.s_arvalid = 1'b1;
        @(negedge clk);
        tick();
        bus.s_arvalid = 1'b0;
        repeat (15) tick();
        inject_dack = 1'b1;
        tick();
        inject_dack = 1'b0;
        @(negedge clk);
        chk("ack16_rvalid_early", 32'(bus.s_rvalid), 32'h0);
        tick();
        @(negedge clk);
        chk("ack16_rvalid", 32'(bus.s_rvalid), 32'h1);
        chk("ack16_rresp", 32'(bus.s_rresp), 32'h0);
        chk("ack16_rdata", bus.s_rdata, 32'h1234_5678);
        tick(); tick();

        // Stray ack while idle is ignored
        inject_dack = 1'b1;
        tick();
        inject_dack = 1'b0;
        repeat (3) tick();
        slave_auto = 1'b1;

        // Backpressure: rready low for 10 cycles, second read pending on ar
        bus.s_rready = 1'b0;
        bus.s_araddr = 10'h008; bus.s_arvalid = 1'b1;
        @(negedge clk);
        chk("bp_arready", 32'(bus.s_arready), 32'h1);
        tick();
        bus.s_araddr = 10'h00C;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rvalid", 32'(bus.s_rvalid), 32'h1);
            chk("bp_rdata", bus.s_rdata, 32'h0000_00C4);
            chk("bp_arready_held", 32'(bus.s_arready), 32'h0);
            chk("bp_nosel", 32'(bus.SirSel), 32'h0);
            tick();
        end
        bus.s_rready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_next_arready", 32'(bus.s_arready), 32'h1);
        tick();
        bus.s_arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.s_rvalid) begin
                got = 1'b1;
                chk("bp_next_rdata", bus.s_rdata, 32'h0000_00C5);
            end
            tick();
        end
        chk("bp_next_done", 32'(got), 32'h1);
        tick();

        // Simultaneous requests after reset: W,R,W,R
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.s_awaddr = 10'h020; bus.s_wdata = 32'h0BAD_F00D; bus.s_araddr = 10'h004;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        ord = 4'b0;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (bus.s_awready) begin ord[ng] = 1'b1; ng++; end
            else if (bus.s_arready) begin ord[ng] = 1'b0; ng++; end
            tick();
        end
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        chk("rr_count", 32'(ng), 32'd4);
        chk("rr_order", 32'(ord), 32'h5);
        repeat (6) tick();

        // Reset in WAIT_ACK drops the write silently
        slave_auto = 1'b0;
        bus.s_awaddr = 10'h030; bus.s_wdata = 32'h5555_AAAA;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(negedge clk);
        chk("ro_awready", 32'(bus.s_awready), 32'h1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ro_write_clr", 32'(bus.SirWrite), 32'h0);
        chk("ro_addr_clr", 32'(bus.SirAddr), 32'h0);
        chk("ro_bvalid", 32'(bus.s_bvalid), 32'h0);
        repeat (4) tick();
        slave_auto = 1'b1;

        // Following write completes normally
        bus.s_awaddr = 10'h040; bus.s_wdata = 32'hDEAD_BEEF;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(negedge clk);
        chk("fw_awready", 32'(bus.s_awready), 32'h1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        @(negedge clk);
        chk("fw_addr", 32'(bus.SirAddr), 32'h10);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.s_bvalid) begin
                got = 1'b1;
                chk("fw_bresp", 32'(bus.s_bresp), 32'h0);
            end
            tick();
        end
        chk("fw_done", 32'(got), 32'h1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
